game_session_scheduler: RTL and testbench
=========================================

// Module: game_session_scheduler
// PURPOSE
//  Sequences game sessions after system_controller reaches GAME_ACTIVE (state==3).
//  Runs a menu for game selection from keypad codes and starts the chosen game with a pulse.
//  Grants that game exclusive keypad ownership and forwards its key presses.
//  Ends the round on game_done, abort key or round timeout, and records why.
// PARAMETERS
//  NUM_GAMES    4    number of game cores, 1..14; key codes 1..NUM_GAMES select a game
//  TICK_DIV     100_000_000  clk cycles per 1 s timer tick (>=2)
//  ROUND_SECS   60   round length in seconds, 1..255
//  ACTIVE_CODE  3    sys_state value that enables this block
// PORTS
//  clk         in   1          system clock
//  rst         in   1          synchronous, active-high reset
//  sys_state   in   8          state from system controller
//  key_code    in   4          decoded keypad code; 0 = no key
//  game_done   in   NUM_GAMES  per-game done level/pulse
//  game_sel    out  clog2(NUM_GAMES)  selected game index
//  game_start  out  1          1-cycle start pulse to selected game
//  game_grant  out  NUM_GAMES  one-hot keypad ownership; 0 outside RUN
//  key_evt     out  4          forwarded key code, valid with key_valid
//  key_valid   out  1          1-cycle pulse per forwarded press
//  secs_left   out  8          remaining round seconds
//  end_cause   out  2          00 none, 01 done, 10 timeout, 11 abort
//  paused      out  1          round paused (0 when feature compiled out)
// BEHAVIOUR
//  - Reset: FSM=MENU; all outputs 0; sel_valid=0; key_q=0.
//  - Press detect: press = (key_code!=0) && (key_q==0); key_q <= key_code each cycle.
//  - Key constants: START=4'hF, ABORT=4'hE, PAUSE=4'hD.
//  - en = (sys_state==ACTIVE_CODE). While !en: FSM forced to MENU next cycle.
//    grant, key_valid, game_start and paused clear. game_sel and end_cause hold.
//  - MENU: press k in 1..NUM_GAMES -> game_sel<=k-1, sel_valid<=1, end_cause<=00.
//    Other codes are ignored. START with sel_valid -> ARM. START without sel_valid is ignored.
//  - ARM (1 cycle): game_start=1, secs_left<=ROUND_SECS, tick counter<=0 -> RUN.
//  - RUN: game_grant = 1<<game_sel. A press other than START/ABORT/PAUSE gives
//    key_evt<=code and key_valid<=1 in the next cycle (1-cycle latency).
//    START and ABORT are never forwarded.
//  - Timer: tick counter counts 0..TICK_DIV-1. At wrap, secs_left decrements.
//    The tick that takes secs_left 1->0 ends the round (timeout).
//  - RUN exit -> END with end_cause. Same-cycle priority: abort(11) > done(01) > timeout(10).
//    Only game_done[game_sel] counts; other bits are ignored.
//  - END: grant=0, timer frozen, secs_left holds. Next press of any key -> MENU.
//    That press is not re-used as a selection. game_sel and sel_valid are kept.
//  - The START press that leaves MENU is never forwarded to the game.
//  - Reset mid-round overrides everything: state and outputs return to their reset values.
// CONFIGURATION
//  SESSION_PAUSE_EN defined:
//    - In RUN, a PAUSE press toggles paused.
//    - While paused: the tick counter freezes, no forwarding, and game_grant stays asserted.
//    - ABORT is still honoured while paused, and paused clears on leaving RUN.
//    - game_done is still honoured while paused.
//  SESSION_PAUSE_EN undefined:
//    - paused is tied to 0.
//    - PAUSE is forwarded like any other game key.
// STRUCTURE
//  Package game_session_pkg:
//    - FSM state encoding MENU/ARM/RUN/END
//    - key constants START/ABORT/PAUSE
//    - end_cause codes
//    - ACTIVE_CODE default
//  Sub-module round_timer:
//    - contains the tick divider and seconds down-counter
//    - ports: load, run, secs_left, expire
//  Top: FSM, press detect, key routing.
// TESTING  (TICK_DIV=4, ROUND_SECS=3, NUM_GAMES=4)
//  - Enable gating: sys_state=2, key 2 then F -> FSM stays MENU, game_start never pulses.
//  - Normal start: sys_state=3, key 2 (release), key F ->
//    game_sel=1, one game_start pulse, then game_grant=4'b0010.
//  - Key forwarding: in RUN, press 5 -> key_valid=1 one cycle later with key_evt=5.
//    Held key 5 for 10 cycles -> exactly one pulse.
//  - Timeout: no input after start -> secs_left 3,2,1,0 at 4-cycle spacing.
//    At 0: END, end_cause=10, game_grant=0.
//  - Priority: game_done[1] and ABORT on the same cycle -> end_cause=11.
//    game_done[3] alone while game 1 runs -> ignored.
//  - Mid-run rst and sys_state drop: rst -> all outputs 0 next edge.
//    sys_state->1 in RUN -> MENU next cycle, grant=0.
//    Pause (SESSION_PAUSE_EN): D freezes secs_left for 20 cycles; second D resumes.

Source files
------------

// File: rtl/game_session_pkg.sv
// Shared encodings for the game session scheduler: FSM states, keypad commands, end causes.
// No logic, so no latency.
// No flow control.
package game_session_pkg;

   typedef enum logic [1:0] {
      ST_MENU = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_END  = 2'd3
   } state_t;

   localparam logic [3:0] KEY_START = 4'hF;
   localparam logic [3:0] KEY_ABORT = 4'hE;
   localparam logic [3:0] KEY_PAUSE = 4'hD;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_DONE    = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
   localparam logic [1:0] CAUSE_ABORT   = 2'b11;

   localparam logic [7:0] ACTIVE_CODE_DEF = 8'd3;

endpackage

// File: rtl/round_timer.sv
// Round clock: divides clk into 1 s ticks and counts the remaining seconds down.
// expire is combinational, high on the tick that takes secs_left from 1 to 0.
// No backpressure; freezes whenever run is low.
module round_timer #(
   parameter int TICK_DIV   = 100_000_000,
   parameter int ROUND_SECS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       run,
   output logic [7:0] secs_left,
   output logic       expire
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] tick_cnt;
   logic          wrap;

   assign wrap   = run && (tick_cnt == LAST);
   assign expire = wrap && (secs_left == 8'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt  <= '0;
         secs_left <= 8'd0;
      end else if (load) begin
         tick_cnt  <= '0;
         secs_left <= 8'(ROUND_SECS);
      end else if (wrap) begin
         tick_cnt <= '0;
         if (secs_left != 8'd0)
            secs_left <= secs_left - 8'd1;
      end else if (run) begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/game_session_scheduler.sv
// Game menu/round sequencer with keypad ownership; SESSION_PAUSE_EN adds a PAUSE key.
// game_start one cycle after START; forwarded keys appear one cycle after the press.
// No backpressure: each press is acted on once; held keys do not repeat.
module game_session_scheduler
   import game_session_pkg::*;
#(
   parameter int         NUM_GAMES   = 4,
   parameter int         TICK_DIV    = 100_000_000,
   parameter int         ROUND_SECS  = 60,
   parameter logic [7:0] ACTIVE_CODE = ACTIVE_CODE_DEF,
   localparam int        SEL_W       = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           sys_state,
   input  logic [3:0]           key_code,
   input  logic [NUM_GAMES-1:0] game_done,
   output logic [SEL_W-1:0]     game_sel,
   output logic                 game_start,
   output logic [NUM_GAMES-1:0] game_grant,
   output logic [3:0]           key_evt,
   output logic                 key_valid,
   output logic [7:0]           secs_left,
   output logic [1:0]           end_cause,
   output logic                 paused
);

   localparam logic [3:0] MAX_KEY = 4'(NUM_GAMES);

   state_t     state, state_nxt;
   logic [3:0] key_q;
   logic       sel_valid;
   logic       en, press, is_game_key, abort_hit, done_hit, pause_hit, fwd_hit;
   logic       timer_load, timer_run, expire;
   logic       sel_load, cause_load, fwd_nxt;
   logic [1:0] cause_nxt;

   assign en          = (sys_state == ACTIVE_CODE);
   assign press       = (key_code != 4'd0) && (key_q == 4'd0);
   assign is_game_key = (key_code >= 4'd1) && (key_code <= MAX_KEY);
   assign abort_hit   = press && (key_code == KEY_ABORT);
   assign done_hit    = game_done[game_sel];
`ifdef SESSION_PAUSE_EN
   assign pause_hit   = press && (key_code == KEY_PAUSE);
`else
   assign pause_hit   = 1'b0;
`endif
   assign fwd_hit     = press && (key_code != KEY_START) && (key_code != KEY_ABORT)
                        && !pause_hit && !paused;

   // Kept outside the FSM process so expire never feeds back into its own block.
   assign timer_load  = en && (state == ST_ARM);
   assign timer_run   = en && (state == ST_RUN) && !paused;

   round_timer #(
      .TICK_DIV   (TICK_DIV),
      .ROUND_SECS (ROUND_SECS)
   ) u_round_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (timer_load),
      .run       (timer_run),
      .secs_left (secs_left),
      .expire    (expire)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_MENU;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      game_start = 1'b0;
      game_grant = '0;
      sel_load   = 1'b0;
      cause_load = 1'b0;
      cause_nxt  = CAUSE_NONE;
      fwd_nxt    = 1'b0;
      if (!en) begin
         state_nxt = ST_MENU;
      end else begin
         case (state)
            ST_MENU: begin
               if (press && is_game_key) begin
                  sel_load   = 1'b1;
                  cause_load = 1'b1;
               end else if (press && (key_code == KEY_START) && sel_valid) begin
                  state_nxt = ST_ARM;
               end
            end
            ST_ARM: begin
               game_start = 1'b1;
               state_nxt  = ST_RUN;
            end
            ST_RUN: begin
               game_grant = NUM_GAMES'(1) << game_sel;
               if (abort_hit) begin
                  state_nxt  = ST_END;
                  cause_load = 1'b1;
                  cause_nxt  = CAUSE_ABORT;
               end else if (done_hit) begin
                  state_nxt  = ST_END;
                  cause_load = 1'b1;
                  cause_nxt  = CAUSE_DONE;
               end else if (expire) begin
                  state_nxt  = ST_END;
                  cause_load = 1'b1;
                  cause_nxt  = CAUSE_TIMEOUT;
               end else begin
                  fwd_nxt = fwd_hit;
               end
            end
            ST_END: begin
               if (press)
                  state_nxt = ST_MENU;
            end
            default: state_nxt = ST_MENU;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q     <= 4'd0;
         sel_valid <= 1'b0;
         game_sel  <= '0;
         end_cause <= CAUSE_NONE;
         key_evt   <= 4'd0;
         key_valid <= 1'b0;
      end else begin
         key_q     <= key_code;
         key_valid <= fwd_nxt;
         if (fwd_nxt)
            key_evt <= key_code;
         if (sel_load) begin
            game_sel  <= SEL_W'(key_code - 4'd1);
            sel_valid <= 1'b1;
         end
         if (cause_load)
            end_cause <= cause_nxt;
      end
   end

`ifdef SESSION_PAUSE_EN
   // Any exit from RUN (or loss of enable) drops the pause.
   always_ff @(posedge clk) begin
      if (rst || !en || (state_nxt != ST_RUN))
         paused <= 1'b0;
      else if ((state == ST_RUN) && pause_hit)
         paused <= !paused;
   end
`else
   assign paused = 1'b0;
`endif

endmodule

// File: tb/tb_game_session_scheduler.sv
// Directed bench for game_session_scheduler (TICK_DIV=4, ROUND_SECS=3, NUM_GAMES=4).
// Start pulses and forwarded keys are matched against queued expectations by a monitor.
module tb_game_session_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sys_state;
   logic [3:0] key_code;
   logic [3:0] game_done;
   logic [1:0] game_sel;
   logic       game_start;
   logic [3:0] game_grant;
   logic [3:0] key_evt;
   logic       key_valid;
   logic [7:0] secs_left;
   logic [1:0] end_cause;
   logic       paused;

   int checks   = 0;
   int failures = 0;

   logic [1:0] start_exp_q[$];
   logic [3:0] key_exp_q[$];

   always #5 clk = ~clk;

   game_session_scheduler #(
      .NUM_GAMES  (4),
      .TICK_DIV   (4),
      .ROUND_SECS (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sys_state  (sys_state),
      .key_code   (key_code),
      .game_done  (game_done),
      .game_sel   (game_sel),
      .game_start (game_start),
      .game_grant (game_grant),
      .key_evt    (key_evt),
      .key_valid  (key_valid),
      .secs_left  (secs_left),
      .end_cause  (end_cause),
      .paused     (paused)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_key(input logic [3:0] k);
      key_code = k;
      tick(1);
      key_code = 4'd0;
      tick(1);
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   initial begin
      logic [1:0] es;
      logic [3:0] ek;
      forever begin
         @(negedge clk);
         if (game_start === 1'b1) begin
            checks++;
            if (start_exp_q.size() == 0) begin
               failures++;
               $display("FAIL start_pulse: unexpected pulse with game_sel=%0d", game_sel);
            end else begin
               es = start_exp_q.pop_front();
               if (game_sel !== es) begin
                  failures++;
                  $display("FAIL start_sel: got %0d expected %0d", game_sel, es);
               end
            end
         end
         if (key_valid === 1'b1) begin
            checks++;
            if (key_exp_q.size() == 0) begin
               failures++;
               $display("FAIL key_fwd: unexpected key_valid with key_evt=%0h", key_evt);
            end else begin
               ek = key_exp_q.pop_front();
               if (key_evt !== ek) begin
                  failures++;
                  $display("FAIL key_evt: got %0h expected %0h", key_evt, ek);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      sys_state = 8'd0;
      key_code  = 4'd0;
      game_done = 4'd0;
      tick(3);
      check("rst_game_sel",   game_sel,   0);
      check("rst_game_start", game_start, 0);
      check("rst_grant",      game_grant, 0);
      check("rst_key_valid",  key_valid,  0);
      check("rst_key_evt",    key_evt,    0);
      check("rst_secs",       secs_left,  0);
      check("rst_cause",      end_cause,  0);
      check("rst_paused",     paused,     0);
      rst = 1'b0;

      // Disabled: selection and START are ignored.
      sys_state = 8'd2;
      tick(1);
      press_key(4'd2);
      press_key(4'hF);
      tick(3);
      check("gate_sel",   game_sel,   0);
      check("gate_grant", game_grant, 0);

      // Round 1: select game 1, start, forward a key, then abort+done+timeout together.
      sys_state = 8'd3;
      tick(1);
      press_key(4'd2);
      check("sel_game1", game_sel, 1);
      start_exp_q.push_back(2'd1);
      press_key(4'hF);
      check("r1_grant", game_grant, 4'b0010);
      check("r1_secs",  secs_left,  3);
      key_exp_q.push_back(4'd5);
      key_code = 4'd5;
      tick(1);
      check("fwd_valid", key_valid, 1);
      check("fwd_evt",   key_evt,   5);
      tick(1);
      check("fwd_pulse_end", key_valid, 0);
      tick(8);
      check("r1_secs_b10", secs_left, 1);
      key_code = 4'd0;
      tick(1);
      key_code  = 4'hE;
      game_done = 4'b0010;
      tick(1);
      check("prio_cause", end_cause,  2'b11);
      check("prio_grant", game_grant, 0);
      key_code  = 4'd0;
      game_done = 4'd0;
      tick(1);

      // END -> MENU on a game key that must not become a new selection.
      key_code = 4'd3;
      tick(3);
      key_code = 4'd0;
      tick(1);
      check("end_key_not_sel", game_sel,  1);
      check("cause_held",      end_cause, 2'b11);

      // Round 2: timeout, with another game's done ignored.
      start_exp_q.push_back(2'd1);
      press_key(4'hF);
      game_done = 4'b1000;
      check("r2_secs3", secs_left, 3);
      tick(4);
      check("r2_secs2", secs_left, 2);
      tick(4);
      check("r2_secs1", secs_left, 1);
      check("r2_grant", game_grant, 4'b0010);
      tick(4);
      check("r2_secs0",  secs_left,  0);
      check("r2_cause",  end_cause,  2'b10);
      check("r2_grant0", game_grant, 0);
      game_done = 4'd0;
      press_key(4'd1);
      press_key(4'd4);
      check("sel_game3",   game_sel,  3);
      check("cause_clear", end_cause, 0);

      // Round 3: PAUSE key handling, START not forwarded, then game_done ends the round.
      start_exp_q.push_back(2'd3);
      press_key(4'hF);
      check("r3_grant", game_grant, 4'b1000);
`ifdef SESSION_PAUSE_EN
      press_key(4'hD);
      check("pause_on", paused, 1);
      press_key(4'd5);
      tick(18);
      check("pause_frozen", secs_left, 3);
      check("pause_grant",  game_grant, 4'b1000);
      press_key(4'hD);
      check("pause_off", paused, 0);
`else
      key_exp_q.push_back(4'hD);
      press_key(4'hD);
      check("nopause_paused", paused, 0);
`endif
      press_key(4'hF);
      check("r3_grant_b4", game_grant, 4'b1000);
      game_done = 4'b1000;
      tick(1);
      check("r3_cause", end_cause,  2'b01);
      check("r3_grant0", game_grant, 0);
      game_done = 4'd0;
      tick(3);
      check("r3_secs_frozen", secs_left, 2);

      // Round 4: enable drop mid-run returns to MENU.
      press_key(4'd1);
      start_exp_q.push_back(2'd3);
      press_key(4'hF);
      check("r4_grant", game_grant, 4'b1000);
      sys_state = 8'd1;
      tick(1);
      check("drop_grant", game_grant, 0);
      check("drop_sel",   game_sel,   3);
      check("drop_cause", end_cause,  2'b01);
      sys_state = 8'd3;
      tick(1);
      start_exp_q.push_back(2'd3);
      press_key(4'hF);
      check("r5_grant", game_grant, 4'b1000);

      // Reset mid-round.
      key_code = 4'd6;
      rst      = 1'b1;
      tick(1);
      check("mid_rst_sel",   game_sel,   0);
      check("mid_rst_grant", game_grant, 0);
      check("mid_rst_secs",  secs_left,  0);
      check("mid_rst_valid", key_valid,  0);
      check("mid_rst_start", game_start, 0);
      rst      = 1'b0;
      key_code = 4'd0;
      tick(1);
      press_key(4'hF);
      tick(3);
      check("start_q_empty", start_exp_q.size(), 0);
      check("key_q_empty",   key_exp_q.size(),   0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
